// File: rtl/uart_echo_bridge.sv
// Buffered UART echo bridge: RX bytes -> optional transform -> FIFO -> start/done TX handshake.
// Optional idle heartbeat byte is built only when UART_ECHO_BRIDGE_HEARTBEAT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for FIFO data (or pending heartbeat)
// LOAD    | tx_data_o register settling
// START   | tx_start_o pulse, timeout timer armed
// WAIT    | frame in flight until tx_done_i or timeout
module uart_echo_bridge #(
    parameter int         FIFO_DEPTH       = 16,
    parameter int         TX_TIMEOUT       = 1_000_000,
    parameter int         HEARTBEAT_CYCLES = 50_000_000,
    parameter logic [7:0] HEARTBEAT_BYTE   = 8'h2E
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_valid_i,
    input  logic [1:0]                    mode_i,
    input  logic                          clear_i,
    output logic [7:0]                    tx_data_o,
    output logic                          tx_start_o,
    input  logic                          tx_done_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          timeout_o,
    output logic                          busy_o
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam int TO_W   = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TX_TIMEOUT - 2);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TX_TIMEOUT < 2 || HEARTBEAT_CYCLES < 2 || $bits(HEARTBEAT_BYTE) != 8) begin : g_bad_timing
        $error("TX_TIMEOUT and HEARTBEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic [7:0] rx_byte;
    logic       rx_keep, push, pop, empty, full, timeout_set;

`ifdef UART_ECHO_BRIDGE_HEARTBEAT_EN
    localparam int HB_W = $clog2(HEARTBEAT_CYCLES);
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_pend_q, hb_pend_d;
    logic            hb_take, hb_wrap;
`endif

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);

    always_comb begin
        rx_byte = rx_data_i;
        rx_keep = 1'b1;
        case (mode_i)
            2'd1:    if (rx_data_i >= 8'h61 && rx_data_i <= 8'h7A) rx_byte = rx_data_i - 8'h20;
            2'd2:    rx_byte = ~rx_data_i;
            2'd3:    rx_keep = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        to_cnt_d    = to_cnt_q;
        pop         = 1'b0;
        timeout_set = 1'b0;
`ifdef UART_ECHO_BRIDGE_HEARTBEAT_EN
        hb_take     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A flush in this cycle wins over starting a new byte.
                if (!clear_i) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        tx_data_d = mem_q[rd_ptr_q];
                        state_d   = ST_LOAD;
                    end
`ifdef UART_ECHO_BRIDGE_HEARTBEAT_EN
                    else if (hb_pend_q) begin
                        hb_take   = 1'b1;
                        tx_data_d = HEARTBEAT_BYTE;
                        state_d   = ST_LOAD;
                    end
`endif
                end
            end
            ST_LOAD:  state_d = ST_START;
            ST_START: begin
                to_cnt_d = TO_LOAD;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    state_d = ST_IDLE;
                end else if (to_cnt_q == '0) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push       = rx_valid_i && rx_keep && !clear_i && (!full || pop);
        overflow_d = clear_i ? 1'b0 : (overflow_q || (rx_valid_i && rx_keep && full && !pop));
        timeout_d  = clear_i ? 1'b0 : (timeout_q || timeout_set);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

`ifdef UART_ECHO_BRIDGE_HEARTBEAT_EN
    // Repeated wraps while a heartbeat is pending collapse into one.
    always_comb begin
        hb_wrap   = (hb_cnt_q == HB_W'(HEARTBEAT_CYCLES - 1));
        hb_cnt_d  = hb_wrap ? '0 : hb_cnt_q + HB_W'(1);
        hb_pend_d = clear_i ? 1'b0 : (hb_wrap || (hb_pend_q && !hb_take));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q  <= '0;
            hb_pend_q <= 1'b0;
        end else begin
            hb_cnt_q  <= hb_cnt_d;
            hb_pend_q <= hb_pend_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_data_q  <= '0;
            to_cnt_q   <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_data_q  <= tx_data_d;
            to_cnt_q   <= to_cnt_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = (state_q == ST_START);
    assign busy_o     = (state_q != ST_IDLE);
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign timeout_o  = timeout_q;
endmodule

// File: tb/tb_uart_echo_bridge.sv
// Scoreboard bench for uart_echo_bridge (default build, small FIFO and short TX timeout).
`timescale 1ns/1ps
module tb_uart_echo_bridge;
    localparam int DEPTH = 4;
    localparam int TOUT  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic [1:0] mode_i = '0;
    logic       clear_i = 1'b0;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_done_i = 1'b0;
    logic [2:0] level_o;
    logic       overflow_o, timeout_o, busy_o;

    uart_echo_bridge #(
        .FIFO_DEPTH(DEPTH), .TX_TIMEOUT(TOUT), .HEARTBEAT_CYCLES(100), .HEARTBEAT_BYTE(8'h2E)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .mode_i(mode_i), .clear_i(clear_i), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
        .tx_done_i(tx_done_i), .level_o(level_o), .overflow_o(overflow_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int errors = 0, checks = 0;
    int n_starts = 0, start_cyc = 0, last_done = -1000, last_gap = 0;
    int done_dly = -1, done_cnt = 0;
    logic [7:0] start_data = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Returns {keep, byte} for the echo-mode transform.
    function automatic logic [8:0] xform(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'd1:    return (d >= 8'h61 && d <= 8'h7A) ? {1'b1, d - 8'h20} : {1'b1, d};
            2'd2:    return {1'b1, ~d};
            2'd3:    return {1'b0, d};
            default: return {1'b1, d};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_done_i) begin
                last_done = cyc;
                if (busy_o) chk("tx_hold", tx_data_o, start_data);
            end
            if (tx_start_o) begin
                n_starts++;
                last_gap   = cyc - last_done;
                start_cyc  = cyc;
                start_data = tx_data_o;
                if (exp_q.size() == 0) chk("extra_tx_count", exp_q.size(), 1);
                else chk("tx_data", tx_data_o, exp_q.pop_front());
                if (done_dly > 0) done_cnt = done_dly;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            tx_done_i = (done_cnt == 1);
            if (done_cnt > 0) done_cnt--;
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m, input bit accept, input bit clr);
        logic [8:0] x;
        x = xform(d, m);
        rx_data_i = d; mode_i = m; rx_valid_i = 1'b1; clear_i = clr;
        if (accept && x[8]) exp_q.push_back(x[7:0]);
        sync();
        rx_valid_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic sample_at(input int c);
        while (cyc < c) sync();
        @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k = 0;
        while (n_starts < target && k < budget) begin sync(); k++; end
        chk("start_count", n_starts, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin sync(); k++; end
        chk("idle_wait", busy_o, 0);
    endtask

    initial begin
        #200_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n, s, base;
        repeat (3) sync();
        chk("rst_start", tx_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_data", tx_data_o, 0);
        rst_n = 1'b1;
        sync();

        // single byte, latency, level and busy timing
        done_dly = 10;
        n = cyc;
        send(8'h61, 2'd0, 1, 0);
        sample_at(n + 1); chk("lvl_n1", level_o, 1);
        sample_at(n + 2); chk("lvl_n2", level_o, 0);
        sync();
        wait_starts(1, 20);
        chk("latency", start_cyc, n + 3);
        wait_idle(50);
        chk("busy_fall", cyc, last_done + 1);

        // transforms, back-to-back spacing, sink mode
        done_dly = 3;
        base = n_starts;
        send(8'h61, 2'd1, 1, 0);
        send(8'h5A, 2'd1, 1, 0);
        send(8'h7B, 2'd1, 1, 0);
        send(8'h0F, 2'd2, 1, 0);
        send(8'h7A, 2'd1, 1, 0);
        send(8'h55, 2'd3, 1, 0);
        wait_starts(base + 5, 200);
        chk("b2b_gap", last_gap, 3);
        wait_idle(50);
        base = n_starts;
        sample_at(cyc + 20);
        chk("sink_starts", n_starts, base);
        chk("sink_level", level_o, 0);

        // overflow with tx_done withheld
        sync();
        done_dly = -1;
        base = n_starts;
        n = cyc;
        for (int i = 1; i <= 6; i++) send(8'(i), 2'd0, (i != 6), 0);
        sample_at(n + 6);
        chk("ovf_level", level_o, 4);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_busy", busy_o, 1);
        done_cnt = 1;
        done_dly = 2;
        sync();
        wait_starts(base + 5, 200);
        wait_idle(50);
        chk("ovf_drain", level_o, 0);
        chk("ovf_sticky", overflow_o, 1);

        // TX timeout then recovery
        done_dly = -1;
        base = n_starts;
        n = cyc;
        send(8'hA5, 2'd0, 1, 0);
        send(8'h3C, 2'd0, 1, 0);
        s = n + 3;
        sample_at(s + TOUT - 1); chk("tmo_early", timeout_o, 0);
        sample_at(s + TOUT);     chk("tmo_set", timeout_o, 1);
        chk("tmo_idle", busy_o, 0);
        done_dly = 3;
        sync();
        wait_starts(base + 2, 20);
        chk("tmo_next_start", start_cyc, s + TOUT + 2);
        wait_idle(50);
        chk("tmo_sticky", timeout_o, 1);
        clear_i = 1'b1; sync(); clear_i = 1'b0;
        chk("clr_ovf", overflow_o, 0);
        chk("clr_tmo", timeout_o, 0);

        // full FIFO with simultaneous push and pop
        done_dly = -1;
        base = n_starts;
        n = cyc;
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 2'd0, 1, 0);
        @(negedge clk);
        chk("full_level", level_o, 4);
        done_cnt = 1;
        sync(); sync();
        send(8'h16, 2'd0, 1, 0);
        chk("pp_level", level_o, 4);
        chk("pp_ovf", overflow_o, 0);
        done_dly = 2;
        wait_starts(base + 6, 200);
        wait_idle(50);
        chk("pp_drain", level_o, 0);

        // clear coincident with rx_valid, in-flight byte completes
        done_dly = -1;
        base = n_starts;
        send(8'h21, 2'd0, 1, 0);
        for (int i = 2; i <= 6; i++) send(8'h20 + 8'(i), 2'd0, 0, 0);
        chk("clr_pre_ovf", overflow_o, 1);
        send(8'h27, 2'd0, 0, 1);
        chk("clr_level", level_o, 0);
        chk("clr_ovf2", overflow_o, 0);
        chk("clr_busy", busy_o, 1);
        @(negedge clk);
        done_cnt = 1;
        sync();
        wait_idle(50);
        sample_at(cyc + 150);
        chk("clr_starts", n_starts, base + 1);
        chk("clr_level_end", level_o, 0);

        // reset mid-frame
        sync();
        base = n_starts;
        send(8'h31, 2'd0, 1, 0);
        send(8'h32, 2'd0, 1, 0);
        wait_starts(base + 1, 20);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_level", level_o, 0);
        chk("mrst_data", tx_data_o, 0);
        exp_q.delete();
        done_cnt = 0;
        sync();
        rst_n = 1'b1;
        base = n_starts;
        sample_at(cyc + 40);
        chk("mrst_no_start", n_starts, base);
        chk("sb_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
